// File: rtl/ws2812b_receiver.sv
// ws2812b_receiver: decodes a WS2812B serial stream into 24-bit GRB words with frame/gap tracking.
module ws2812b_receiver #(
  parameter int BIT_THRESH   = 6,
  parameter int HIGH_MIN     = 2,
  parameter int HIGH_MAX     = 20,
  parameter int RESET_CYCLES = 500
) (
  input  logic        clk,
  input  logic        res_n,
  input  logic        din,
  output logic [23:0] data,
  output logic        word_valid,
  output logic [3:0]  led_index,
  output logic        frame_done,
  output logic        err
);
  localparam logic [1:0] SYNC = 2'd0, LOW = 2'd1, HIGH = 2'd2, DISCARD = 2'd3;
  logic [1:0]  state;
  logic        s1, din_s;
  logic [15:0] lo_cnt, lo_nxt;
  logic [7:0]  hi_cnt, hi_nxt;
  logic [23:0] shift;
  logic [4:0]  bit_cnt;
  logic [3:0]  word_cnt;
  logic        gap, fall, bad, bit_v;
  always_comb begin
    lo_nxt = din_s ? 16'd0 : lo_cnt + 16'(lo_cnt != 16'hffff);
    hi_nxt = din_s ? hi_cnt + 8'(hi_cnt != 8'hff) : 8'd0;
    gap    = lo_nxt == 16'(RESET_CYCLES);
    fall   = state == HIGH && !din_s;
    bad    = hi_cnt < 8'(HIGH_MIN) || hi_cnt > 8'(HIGH_MAX);
    bit_v  = hi_cnt >= 8'(BIT_THRESH);
  end
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      {din_s, s1} <= 2'b00;
      state       <= SYNC;
      lo_cnt      <= '0;
      hi_cnt      <= '0;
      shift       <= '0;
      bit_cnt     <= '0;
      word_cnt    <= '0;
      data        <= '0;
      led_index   <= '0;
      word_valid  <= 1'b0;
      frame_done  <= 1'b0;
      err         <= 1'b0;
    end else begin
      {din_s, s1} <= {s1, din};
      lo_cnt      <= lo_nxt;
      hi_cnt      <= hi_nxt;
      word_valid  <= 1'b0;
      frame_done  <= 1'b0;
      err         <= 1'b0;
      if (state == SYNC) begin
        if (gap) state <= LOW;
      end else if (state != HIGH && gap) begin
        frame_done <= 1'b1;
        state      <= LOW;
        shift      <= '0;
        bit_cnt    <= '0;
        word_cnt   <= '0;
        led_index  <= '0;
      end else if (state == LOW && din_s) begin
        state <= HIGH;
      end else if (state == HIGH && hi_nxt == 8'(HIGH_MAX + 1)) begin
        err   <= 1'b1;
        state <= DISCARD;
      end else if (fall && bad) begin
        err   <= 1'b1;
        state <= DISCARD;
      end else if (fall) begin
        state <= LOW;
        shift <= {shift[22:0], bit_v};
        if (bit_cnt == 5'd23) begin
          bit_cnt    <= '0;
          data       <= {shift[22:0], bit_v};
          word_valid <= 1'b1;
          led_index  <= word_cnt;
          word_cnt   <= word_cnt + 4'(word_cnt != 4'd15);
        end else begin
          bit_cnt <= bit_cnt + 5'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_ws2812b_receiver.sv
// tb_ws2812b_receiver: scoreboard bench for the WS2812B receiver.
module tb_ws2812b_receiver;
  logic        clk = 1'b0, res_n = 1'b0, din = 1'b0;
  logic [23:0] data;
  logic        word_valid, frame_done, err;
  logic [3:0]  led_index;

  typedef struct {logic [1:0] kind; logic [23:0] d; logic [3:0] idx;} ev_t;
  typedef struct {logic [23:0] w; logic [3:0] idx;} vec_t;
  ev_t q[$];
  int vectors = 0, miscompares = 0;

  ws2812b_receiver dut (.clk(clk), .res_n(res_n), .din(din), .data(data), .word_valid(word_valid),
                        .led_index(led_index), .frame_done(frame_done), .err(err));

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(logic [1:0] k, logic [23:0] d, logic [3:0] i);
    ev_t e;
    e.kind = k; e.d = d; e.idx = i;
    q.push_back(e);
  endtask

  task automatic pop_chk(logic [1:0] k);
    ev_t e;
    if (q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_event: got kind %0d expected no event", k);
    end else begin
      e = q.pop_front();
      chk("event_kind", 32'(k), 32'(e.kind));
      if (k == 2'd0) begin
        chk("data", 32'(data), 32'(e.d));
        chk("led_index", 32'(led_index), 32'(e.idx));
      end
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (word_valid) begin
      chk("word_vs_frame", 32'(frame_done), 32'd0);
      pop_chk(2'd0);
    end
    if (frame_done) pop_chk(2'd1);
    if (err) pop_chk(2'd2);
  end

  task automatic send_bit(logic b);
    din = 1'b1;
    repeat (b ? 8 : 4) @(negedge clk);
    din = 1'b0;
    repeat (b ? 4 : 8) @(negedge clk);
  endtask

  task automatic send_bits(logic [23:0] w, int n);
    for (int i = 23; i > 23 - n; i--) send_bit(w[i]);
  endtask

  task automatic low(int n);
    din = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    vec_t tbl[3];
    tbl[0] = '{24'h123456, 4'd0};
    tbl[1] = '{24'hABCDEF, 4'd1};
    tbl[2] = '{24'h000001, 4'd2};
    repeat (3) @(negedge clk);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_wv", 32'(word_valid), 32'd0);
    chk("rst_fd", 32'(frame_done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_idx", 32'(led_index), 32'd0);
    res_n = 1'b1;
    low(510);
    // first word, with exact third-edge latency on the final falling edge
    expect_ev(2'd0, 24'hFF0000, 4'd0);
    send_bits(24'hFF0000, 23);
    din = 1'b1;
    repeat (4) @(negedge clk);
    din = 1'b0;
    @(posedge clk); #1 chk("lat_edge1", 32'(word_valid), 32'd0);
    @(posedge clk); #1 chk("lat_edge2", 32'(word_valid), 32'd0);
    @(posedge clk); #1 chk("lat_edge3", 32'(word_valid), 32'd1);
    low(8);
    expect_ev(2'd1, 24'd0, 4'd0);
    low(500);
    foreach (tbl[i]) begin
      expect_ev(2'd0, tbl[i].w, tbl[i].idx);
      send_bits(tbl[i].w, 24);
    end
    expect_ev(2'd1, 24'd0, 4'd0);
    low(500);
    expect_ev(2'd0, 24'h5A5A5A, 4'd0);
    send_bits(24'h5A5A5A, 24);
    // glitch after 10 bits discards the rest of the frame
    send_bits(24'h3C3C3C, 10);
    expect_ev(2'd2, 24'd0, 4'd0);
    din = 1'b1;
    @(negedge clk);
    low(8);
    send_bits(24'h777777, 24);
    expect_ev(2'd1, 24'd0, 4'd0);
    low(500);
    expect_ev(2'd0, 24'hC3C3C3, 4'd0);
    send_bits(24'hC3C3C3, 24);
    // overlong high: err exactly at high count 21
    expect_ev(2'd2, 24'd0, 4'd0);
    din = 1'b1;
    repeat (22) @(posedge clk);
    #1 chk("overlong_early", 32'(err), 32'd0);
    @(posedge clk); #1 chk("overlong_at21", 32'(err), 32'd1);
    @(negedge clk);
    repeat (7) @(negedge clk);
    expect_ev(2'd1, 24'd0, 4'd0);
    low(500);
    chk("data_hold", 32'(data), 32'hC3C3C3);
    // partial word then gap
    send_bits(24'hF0F0F0, 12);
    expect_ev(2'd1, 24'd0, 4'd0);
    low(500);
    expect_ev(2'd0, 24'h00FF00, 4'd0);
    send_bits(24'h00FF00, 24);
    // reset mid-word, then no decoding until a full gap
    send_bits(24'hAAAAAA, 10);
    res_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_data", 32'(data), 32'd0);
    chk("midrst_idx", 32'(led_index), 32'd0);
    @(negedge clk);
    res_n = 1'b1;
    send_bits(24'h654321, 24);
    low(500);
    for (int i = 0; i < 17; i++) begin
      expect_ev(2'd0, 24'(i * 24'h010203 + 24'h100000), 4'(i > 15 ? 15 : i));
      send_bits(24'(i * 24'h010203 + 24'h100000), 24);
    end
    expect_ev(2'd1, 24'd0, 4'd0);
    low(500);
    repeat (5) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
